// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler
//   Owns the single write port of the display pixel memory. Each accepted
//   frame_start clears the panel one pixel per cycle. Then it grants the port
//   to the physics renderer through a valid/ready request channel until the
//   renderer reports draw_done, or until the optional DRAW timeout expires.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   frame_start         one-cycle pulse that starts a new frame
//   clear_color[8:0]    background colour, latched when frame_start is taken
//   req_valid/ready     renderer request channel (see handshake note below)
//   req_x/y/color       requested pixel write
//   draw_done           one-cycle pulse; renderer finished the frame
//   write_en/x/y/color  registered pixel-memory write port to display
//   busy                high in any state other than IDLE
//   frame_done          one-cycle pulse when a frame completes normally
//   overrun             sticky; a frame_start arrived while not IDLE
//
// Handshake: a request transfers on any cycle where req_valid && req_ready.
// req_ready depends only on state (high in every DRAW cycle). It never
// depends on req_valid. An accepted request appears on write_* one cycle
// later. Out-of-panel requests are accepted but dropped.
module frame_draw_scheduler #(
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int DRAW_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [8:0] clear_color,
  input  logic       req_valid,
  input  logic [5:0] req_x,
  input  logic [5:0] req_y,
  input  logic [8:0] req_color,
  output logic       req_ready,
  input  logic       draw_done,
  output logic       write_en,
  output logic [5:0] write_x,
  output logic [5:0] write_y,
  output logic [8:0] write_color,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0]  X_LAST       = 6'(WIDTH - 1);
  localparam logic [5:0]  Y_LAST       = 6'(HEIGHT - 1);
  localparam logic [6:0]  X_LIMIT      = 7'(WIDTH);
  localparam logic [6:0]  Y_LIMIT      = 7'(HEIGHT);
  localparam logic [19:0] TIMEOUT_LAST = 20'(DRAW_TIMEOUT - 1);
  localparam logic        TIMEOUT_ON   = (DRAW_TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [5:0]  clear_x_q, clear_x_d;
  logic [5:0]  clear_y_q, clear_y_d;
  logic [8:0]  color_q, color_d;
  logic [19:0] timer_q, timer_d;
  logic        write_en_q, write_en_d;
  logic [5:0]  write_x_q, write_x_d;
  logic [5:0]  write_y_q, write_y_d;
  logic [8:0]  write_color_q, write_color_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;

  logic        accept;
  logic        in_panel;

  assign req_ready = (state_q == S_DRAW);
  assign accept    = req_valid && req_ready;
  // Widen by one bit so WIDTH/HEIGHT = 64 compare correctly against 6-bit coords.
  assign in_panel  = ({1'b0, req_x} < X_LIMIT) && ({1'b0, req_y} < Y_LIMIT);

  always_comb begin
    state_d       = state_q;
    clear_x_d     = clear_x_q;
    clear_y_d     = clear_y_q;
    color_d       = color_q;
    timer_d       = timer_q;
    write_en_d    = 1'b0;
    write_x_d     = write_x_q;
    write_y_d     = write_y_q;
    write_color_d = write_color_q;
    overrun_d     = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          color_d   = clear_color;
          clear_x_d = '0;
          clear_y_d = '0;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        write_en_d    = 1'b1;
        write_x_d     = clear_x_q;
        write_y_d     = clear_y_q;
        write_color_d = color_q;
        if (clear_x_q == X_LAST) begin
          clear_x_d = '0;
          if (clear_y_q == Y_LAST) begin
            clear_y_d = '0;
            timer_d   = '0;
            state_d   = S_DRAW;
          end else begin
            clear_y_d = clear_y_q + 6'd1;
          end
        end else begin
          clear_x_d = clear_x_q + 6'd1;
        end
      end

      S_DRAW: begin
        if (accept && in_panel) begin
          write_en_d    = 1'b1;
          write_x_d     = req_x;
          write_y_d     = req_y;
          write_color_d = req_color;
        end
        if (draw_done) begin
          state_d = S_DONE;
        end else if (TIMEOUT_ON && (timer_q == TIMEOUT_LAST)) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new frame_start preempts whatever is in flight. A DRAW write already
    // scheduled above is kept. Because state_d is forced to CLEAR here, the
    // aborted frame never reaches DONE and never pulses frame_done.
    if (frame_start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
      color_d   = clear_color;
      clear_x_d = '0;
      clear_y_d = '0;
      state_d   = S_CLEAR;
    end

    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clear_x_q     <= '0;
      clear_y_q     <= '0;
      color_q       <= '0;
      timer_q       <= '0;
      write_en_q    <= 1'b0;
      write_x_q     <= '0;
      write_y_q     <= '0;
      write_color_q <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_x_q     <= clear_x_d;
      clear_y_q     <= clear_y_d;
      color_q       <= color_d;
      timer_q       <= timer_d;
      write_en_q    <= write_en_d;
      write_x_q     <= write_x_d;
      write_y_q     <= write_y_d;
      write_color_q <= write_color_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign write_en    = write_en_q;
  assign write_x     = write_x_q;
  assign write_y     = write_y_q;
  assign write_color = write_color_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule
